inst_sram_responder: RTL and testbench



---
 rtl/inst_sram_responder.sv | 125 ++++++++++++
 tb/tb_inst_sram_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// inst_sram_responder
//   Slave end of the instruction SRAM-like interface used by the fetch stage.
//   It serves word reads with one cycle of latency, accepts byte-enabled
//   writes (read-first), holds the read data while no request is presented,
//   and keeps a sticky record of the first out-of-window access.
//
// Ports
//   clk, resetn       clock; asynchronous active-low reset
//   inst_sram_en      request strobe, sampled at posedge
//   inst_sram_wen     byte-lane write enables (0 = read)
//   inst_sram_addr    byte address
//   inst_sram_wdata   write data
//   inst_sram_rdata   registered read data (held while en=0)
//   rdata_valid       high in the cycle after an accepted request
//   err_clr           clears the sticky error record
//   err_flag          an out-of-window access has occurred
//   err_addr          address of the first out-of-window access since clear

// One byte lane of the instruction store. The array is not reset, so its
// contents survive resetn. The read port is combinational; the top samples it
// at the same edge a write commits, which gives read-first behaviour.
module inst_sram_lane #(
  parameter int DEPTH_LOG2 = 12,
  parameter int VEC_W      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [VEC_W-1:0]      wbyte,
  output logic [VEC_W-1:0]      rbyte
);
  logic [VEC_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wbyte;
  end

  assign rbyte = mem[idx];
endmodule

module inst_sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] FILL_INST  = 32'h03400000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        rdata_valid,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [31:0] err_addr
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int STAGES    = 1;
  // Window size in bytes, one bit wider so the compare never overflows.
  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

  typedef struct packed {
    logic                              en;
    logic [NUM_LANES-1:0]              wen;
    logic [31:0]                       addr;
    logic [NUM_LANES-1:0][VEC_W-1:0]   wdata;
  } req_t;

  req_t                            req;
  logic [31:0]                     offset;
  logic                            in_win;
  logic                            err_evt;
  logic [DEPTH_LOG2-1:0]           idx;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_rd;
  logic [STAGES:0]                 vld_pipe;

  assign req = '{en: inst_sram_en, wen: inst_sram_wen,
                 addr: inst_sram_addr, wdata: inst_sram_wdata};

  // Addresses below the base wrap to a huge offset and land out of window.
  assign offset  = req.addr - ADDR_BASE;
  assign in_win  = {1'b0, offset} < WIN_BYTES;
  assign idx     = offset[DEPTH_LOG2+1:2];
  assign err_evt = req.en & ~in_win;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    inst_sram_lane #(.DEPTH_LOG2(DEPTH_LOG2), .VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .we    (req.en & in_win & req.wen[l]),
      .idx   (idx),
      .wbyte (req.wdata[l]),
      .rbyte (lane_rd[l])
    );
  end

  assign vld_pipe[0] = req.en;
  assign rdata_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe[STAGES:1] <= '0;
      inst_sram_rdata    <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Without a request the data is held for a stalled fetch stage.
      if (req.en) inst_sram_rdata <= in_win ? lane_rd : FILL_INST;
    end
  end

  // A new error beats a simultaneous clear, so the record is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_evt && (!err_flag || err_clr)) begin
      err_flag <= 1'b1;
      err_addr <= req.addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end
  end
endmodule

// File: tb/tb_inst_sram_responder.sv
module tb_inst_sram_responder;
  localparam logic [31:0] BASE = 32'h1c000000;
  localparam logic [31:0] FILL = 32'h03400000;
  localparam int          NWORDS = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        clr;
  logic [31:0] rdata;
  logic        valid;
  logic        eflag;
  logic [31:0] eaddr;

  int checks = 0;
  int errors = 0;

  inst_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (en),
    .inst_sram_wen   (wen),
    .inst_sram_addr  (addr),
    .inst_sram_wdata (wdata),
    .inst_sram_rdata (rdata),
    .rdata_valid     (valid),
    .err_clr         (clr),
    .err_flag        (eflag),
    .err_addr        (eaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_vld;
    logic        exp_flag;
    logic [31:0] exp_ea;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request, let one edge pass, sample 1 ns later.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic c);
    en = e; wen = w; addr = a; wdata = d; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; wen = 4'h0; clr = 1'b0;
  endtask

  function automatic vec_t mk(logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                              logic c, logic cr, logic [31:0] r, logic v,
                              logic f, logic [31:0] ea);
    vec_t x;
    x.en = e; x.wen = w; x.addr = a; x.wdata = d; x.clr = c;
    x.chk_rd = cr; x.exp_rd = r; x.exp_vld = v; x.exp_flag = f; x.exp_ea = ea;
    return x;
  endfunction

  // Reference model: word store for a small region, plus interface state.
  logic [31:0] mdl_mem [0:15];
  logic [31:0] m_rd;
  logic        m_flag;
  logic [31:0] m_ea;

  function automatic bit out_of_window(logic [31:0] a);
    return (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * NWORDS));
  endfunction

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; clr = 1'b0;
    #3;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_flag", 32'(eflag), 32'h0);
    chk("reset_eaddr", eaddr, 32'h0);
    #9 resetn = 1'b1;

    // Directed vectors, applied in order from reset.
    vt.push_back(mk(1, 4'hf, 32'h1c000000, 32'h02800421, 0, 0, 0,            1, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c000000, 32'h0,        0, 1, 32'h02800421, 1, 0, 0));
    vt.push_back(mk(1, 4'hf, 32'h1c000004, 32'h11223344, 0, 0, 0,            1, 0, 0));
    vt.push_back(mk(1, 4'h5, 32'h1c000004, 32'haabbccdd, 0, 1, 32'h11223344, 1, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c000004, 32'h0,        0, 1, 32'h11bb33dd, 1, 0, 0));
    vt.push_back(mk(1, 4'hf, 32'h1c000008, 32'h0,        0, 0, 0,            1, 0, 0));
    vt.push_back(mk(1, 4'hf, 32'h1c000008, 32'hdeadbeef, 0, 1, 32'h0,        1, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c000008, 32'h0,        0, 1, 32'hdeadbeef, 1, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1bfffffc, 32'h0,        0, 1, FILL,         1, 1, 32'h1bfffffc));
    vt.push_back(mk(1, 4'h0, 32'h1c004000, 32'h0,        0, 1, FILL,         1, 1, 32'h1bfffffc));
    vt.push_back(mk(1, 4'h0, 32'h20000000, 32'h0,        1, 1, FILL,         1, 1, 32'h20000000));
    vt.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 1, FILL,         0, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c003ffc, 32'h0,        0, 0, 0,            1, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c000003, 32'h0,        0, 1, 32'h02800421, 1, 0, 0));
    vt.push_back(mk(1, 4'hf, 32'h1c004000, 32'h12345678, 0, 1, FILL,         1, 1, 32'h1c004000));
    vt.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 1, FILL,         0, 0, 0));
    vt.push_back(mk(1, 4'h0, 32'h1c004000, 32'h0,        0, 1, FILL,         1, 1, 32'h1c004000));
    vt.push_back(mk(1, 4'h0, 32'h1c000008, 32'h0,        1, 1, 32'hdeadbeef, 1, 0, 0));

    @(posedge clk); #1;
    foreach (vt[i]) begin
      cyc(vt[i].en, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].clr);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].exp_vld));
      chk($sformatf("vec%0d_flag", i), 32'(eflag), 32'(vt[i].exp_flag));
      chk($sformatf("vec%0d_eaddr", i), eaddr, vt[i].exp_ea);
    end

    // Hold while stalled.
    cyc(1, 4'h0, 32'h1c000000, 32'h0, 0);
    chk("hold_first", rdata, 32'h02800421);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'h0, 32'h1c000008, 32'h0, 0);
      chk($sformatf("hold%0d_rdata", i), rdata, 32'h02800421);
      chk($sformatf("hold%0d_valid", i), 32'(valid), 32'h0);
    end

    // Async reset in the cycle after a write; the write must persist.
    cyc(1, 4'h0, 32'h1bfffff0, 32'h0, 0);
    chk("pre_rst_flag", 32'(eflag), 32'h1);
    cyc(1, 4'hf, 32'h1c00000c, 32'hcafef00d, 0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_flag", 32'(eflag), 32'h0);
    chk("async_rst_eaddr", eaddr, 32'h0);
    #3 resetn = 1'b1;
    cyc(1, 4'h0, 32'h1c000000, 32'h0, 0);
    chk("post_rst_word0", rdata, 32'h02800421);
    chk("post_rst_valid", 32'(valid), 32'h1);
    cyc(1, 4'h0, 32'h1c00000c, 32'h0, 0);
    chk("post_rst_word3", rdata, 32'hcafef00d);

    // Randomized traffic against the model over words 0..15.
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = $urandom;
      cyc(1, 4'hf, BASE + 32'(4 * i), mdl_mem[i], 0);
    end
    cyc(1, 4'h0, BASE, 32'h0, 1);
    m_rd = mdl_mem[0]; m_flag = 1'b0; m_ea = 32'h0;
    chk("rand_start_rdata", rdata, m_rd);

    for (int n = 0; n < 400; n++) begin
      logic        e, c, v;
      logic [3:0]  w;
      logic [31:0] a, d;
      int          k;
      e = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d = $urandom;
      c = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0: a = BASE - 32'($urandom_range(1, 64));
        1: a = BASE + 32'(4 * NWORDS) + 32'($urandom_range(0, 64));
        2: a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      // Model step, using the pre-edge store for the read-first result.
      v = e;
      if (e) begin
        if (out_of_window(a)) begin
          m_rd = FILL;
          if (!m_flag || c) begin m_flag = 1'b1; m_ea = a; end
          else if (c) begin m_flag = 1'b0; m_ea = 0; end
        end else begin
          k = int'((a - BASE) / 4);
          m_rd = mdl_mem[k];
          for (int b = 0; b < 4; b++)
            if (w[b]) mdl_mem[k][8*b +: 8] = d[8*b +: 8];
          if (c) begin m_flag = 1'b0; m_ea = 0; end
        end
      end else if (c) begin
        m_flag = 1'b0; m_ea = 0;
      end
      cyc(e, w, a, d, c);
      chk($sformatf("rand%0d_rdata a=%h", n, a), rdata, m_rd);
      chk($sformatf("rand%0d_valid", n), 32'(valid), 32'(v));
      chk($sformatf("rand%0d_flag", n), 32'(eflag), 32'(m_flag));
      chk($sformatf("rand%0d_eaddr", n), eaddr, m_ea);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
